// File: rtl/posit_mul_ctrl.sv
// Sequencing controller for the posit multiplier datapath.
// Launches exp/mantissa units, then the encoder, and returns one token.
module posit_mul_ctrl #(
  parameter int ES      = 3,
  parameter int K_BITS  = 6,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_nar_A,
  input  logic in_nar_B,
  input  logic in_zero_A,
  input  logic in_zero_B,
  output logic ea_start,
  input  logic ea_done,
  input  logic ea_NaR,
  input  logic ea_zero,
  output logic mm_start,
  input  logic mm_done,
  output logic enc_start,
  input  logic enc_done,
  output logic out_valid,
  input  logic out_ready,
  output logic out_nar,
  output logic out_zero,
  output logic busy,
  output logic err_timeout
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  if (TIMEOUT < 2 || ES < 0 || K_BITS < 1) begin : g_bad_param
    $error("posit_mul_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_EM,
    S_WAIT_ENC,
    S_OUT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ea_seen_q, ea_seen_d;
  logic          mm_seen_q, mm_seen_d;
  logic          ea_nar_q, ea_nar_d;
  logic          ea_zro_q, ea_zro_d;
  logic          in_ready_q, in_ready_d;
  logic          ea_start_q, ea_start_d;
  logic          mm_start_q, mm_start_d;
  logic          enc_start_q, enc_start_d;
  logic          out_valid_q, out_valid_d;
  logic          out_nar_q, out_nar_d;
  logic          out_zero_q, out_zero_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic ea_hit, mm_hit, nar_eff, zro_eff;
  logic accept, cnt_last;

  assign accept   = in_valid && in_ready_q;
  assign cnt_last = (cnt_q == CNT_LAST);
  assign ea_hit   = ea_seen_q | ea_done;
  assign mm_hit   = mm_seen_q | mm_done;
  // Overflow flags are only meaningful with ea_done; else use the latch.
  assign nar_eff  = ea_done ? ea_NaR  : ea_nar_q;
  assign zro_eff  = ea_done ? ea_zero : ea_zro_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ea_seen_d   = ea_seen_q;
    mm_seen_d   = mm_seen_q;
    ea_nar_d    = ea_nar_q;
    ea_zro_d    = ea_zro_q;
    ea_start_d  = 1'b0;
    mm_start_d  = 1'b0;
    enc_start_d = 1'b0;
    out_valid_d = out_valid_q;
    out_nar_d   = out_nar_q;
    out_zero_d  = out_zero_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_nar_A | in_nar_B) begin
            state_d     = S_OUT;
            out_valid_d = 1'b1;
            out_nar_d   = 1'b1;
            out_zero_d  = 1'b0;
          end else if (in_zero_A | in_zero_B) begin
            state_d     = S_OUT;
            out_valid_d = 1'b1;
            out_nar_d   = 1'b0;
            out_zero_d  = 1'b1;
          end else begin
            state_d    = S_WAIT_EM;
            ea_start_d = 1'b1;
            mm_start_d = 1'b1;
            cnt_d      = '0;
            ea_seen_d  = 1'b0;
            mm_seen_d  = 1'b0;
            ea_nar_d   = 1'b0;
            ea_zro_d   = 1'b0;
          end
        end
      end
      S_WAIT_EM: begin
        if (ea_done) begin
          ea_seen_d = 1'b1;
          ea_nar_d  = ea_NaR;
          ea_zro_d  = ea_zero;
        end
        if (mm_done) mm_seen_d = 1'b1;
        if (ea_hit && mm_hit) begin
          ea_seen_d = 1'b0;
          mm_seen_d = 1'b0;
          if (nar_eff) begin
            state_d     = S_OUT;
            out_valid_d = 1'b1;
            out_nar_d   = 1'b1;
            out_zero_d  = 1'b0;
          end else if (zro_eff) begin
            state_d     = S_OUT;
            out_valid_d = 1'b1;
            out_nar_d   = 1'b0;
            out_zero_d  = 1'b1;
          end else begin
            state_d     = S_WAIT_ENC;
            enc_start_d = 1'b1;
            cnt_d       = '0;
          end
        end else if (cnt_last) begin
          state_d     = S_OUT;
          out_valid_d = 1'b1;
          out_nar_d   = 1'b1;
          out_zero_d  = 1'b0;
          err_d       = 1'b1;
          ea_seen_d   = 1'b0;
          mm_seen_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_ENC: begin
        if (enc_done) begin
          state_d     = S_OUT;
          out_valid_d = 1'b1;
          out_nar_d   = 1'b0;
          out_zero_d  = 1'b0;
        end else if (cnt_last) begin
          state_d     = S_OUT;
          out_valid_d = 1'b1;
          out_nar_d   = 1'b1;
          out_zero_d  = 1'b0;
          err_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          out_nar_d   = 1'b0;
          out_zero_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ea_seen_q   <= 1'b0;
      mm_seen_q   <= 1'b0;
      ea_nar_q    <= 1'b0;
      ea_zro_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      ea_start_q  <= 1'b0;
      mm_start_q  <= 1'b0;
      enc_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_nar_q   <= 1'b0;
      out_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ea_seen_q   <= ea_seen_d;
      mm_seen_q   <= mm_seen_d;
      ea_nar_q    <= ea_nar_d;
      ea_zro_q    <= ea_zro_d;
      in_ready_q  <= in_ready_d;
      ea_start_q  <= ea_start_d;
      mm_start_q  <= mm_start_d;
      enc_start_q <= enc_start_d;
      out_valid_q <= out_valid_d;
      out_nar_q   <= out_nar_d;
      out_zero_q  <= out_zero_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign ea_start    = ea_start_q;
  assign mm_start    = mm_start_q;
  assign enc_start   = enc_start_q;
  assign out_valid   = out_valid_q;
  assign out_nar     = out_nar_q;
  assign out_zero    = out_zero_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_posit_mul_ctrl.sv
// Bench for posit_mul_ctrl: vector table with scoreboard queue,
// plus hand sequences for reset and mid-flight reset.
module tb_posit_mul_ctrl;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready;
  logic in_nar_A, in_nar_B, in_zero_A, in_zero_B;
  logic ea_start, ea_done, ea_NaR, ea_zero;
  logic mm_start, mm_done, enc_start, enc_done;
  logic out_valid, out_ready, out_nar, out_zero, busy, err_timeout;

  always #5 clk = ~clk;

  posit_mul_ctrl #(.ES(3), .K_BITS(6), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_nar_A(in_nar_A), .in_nar_B(in_nar_B),
    .in_zero_A(in_zero_A), .in_zero_B(in_zero_B),
    .ea_start(ea_start), .ea_done(ea_done),
    .ea_NaR(ea_NaR), .ea_zero(ea_zero),
    .mm_start(mm_start), .mm_done(mm_done),
    .enc_start(enc_start), .enc_done(enc_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_nar(out_nar), .out_zero(out_zero),
    .busy(busy), .err_timeout(err_timeout)
  );

  localparam int NEVER = 1000;

  typedef struct {
    string name;
    bit na, nb, za, zb, enar, ezero;
    int ea_lat, mm_lat, enc_lat, hold;
    bit x_nar, x_zero;
    int x_em, x_enc;
    bit x_to;
    int x_lat;
  } vec_t;

  typedef struct {
    bit nar, zero;
    int em, enc;
    bit to;
    int lat;
  } exp_t;

  exp_t sb[$];
  vec_t vt[14];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   exp_err = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic vec_t mk(
    input string nm, input bit na, nb, za, zb, enar, ezero,
    input int eal, mml, encl, hold,
    input bit xn, xz, input int xem, xenc, input bit xto, input int xlat);
    vec_t v;
    v.name = nm; v.na = na; v.nb = nb; v.za = za; v.zb = zb;
    v.enar = enar; v.ezero = ezero;
    v.ea_lat = eal; v.mm_lat = mml; v.enc_lat = encl; v.hold = hold;
    v.x_nar = xn; v.x_zero = xz; v.x_em = xem; v.x_enc = xenc;
    v.x_to = xto; v.x_lat = xlat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t e;
    int ea_s, mm_s, enc_s, ea_c, mm_c, enc_c;
    bit got;
    chk({v.name, "_idle_rdy"}, int'(in_ready), 1);
    in_valid  = 1'b1;
    in_nar_A  = v.na; in_nar_B  = v.nb;
    in_zero_A = v.za; in_zero_B = v.zb;
    e.nar = v.x_nar; e.zero = v.x_zero; e.em = v.x_em;
    e.enc = v.x_enc; e.to = v.x_to; e.lat = v.x_lat;
    sb.push_back(e);
    @(negedge clk);
    in_valid  = 1'b0;
    in_nar_A  = 1'b1; in_nar_B  = 1'b1;
    in_zero_A = 1'b1; in_zero_B = 1'b1;
    ea_s = 0; mm_s = 0; enc_s = 0;
    ea_c = 0; mm_c = 0; enc_c = 0;
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      if (ea_start)  begin ea_s++;  ea_c  = c; end
      if (mm_start)  begin mm_s++;  mm_c  = c; end
      if (enc_start) begin enc_s++; enc_c = c; end
      if (out_valid) begin
        got = 1'b1;
        e = sb.pop_front();
        if (e.to) exp_err = 1'b1;
        chk({v.name, "_nar"}, int'(out_nar), int'(e.nar));
        chk({v.name, "_zero"}, int'(out_zero), int'(e.zero));
        chk({v.name, "_ea_pulses"}, ea_s, e.em);
        chk({v.name, "_mm_pulses"}, mm_s, e.em);
        chk({v.name, "_enc_pulses"}, enc_s, e.enc);
        chk({v.name, "_latency"}, c, e.lat);
        chk({v.name, "_err"}, int'(err_timeout), int'(exp_err));
        chk({v.name, "_rdy_low"}, int'(in_ready), 0);
        chk({v.name, "_busy"}, int'(busy), 1);
        ea_done = 1'b0; ea_NaR = 1'b0; ea_zero = 1'b0;
        mm_done = 1'b0; enc_done = 1'b0;
      end else begin
        ea_done  = (ea_s > 0) && (c == ea_c + v.ea_lat);
        ea_NaR   = ea_done & v.enar;
        ea_zero  = ea_done & v.ezero;
        mm_done  = (mm_s > 0) && (c == mm_c + v.mm_lat);
        enc_done = (enc_s > 0) && (c == enc_c + v.enc_lat);
        @(negedge clk);
      end
    end
    if (!got) begin
      chk({v.name, "_out_valid_timeout"}, 0, 1);
      void'(sb.pop_front());
      ea_done = 1'b0; mm_done = 1'b0; enc_done = 1'b0;
      ea_NaR = 1'b0; ea_zero = 1'b0;
      return;
    end
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk({v.name, "_hold_valid"}, int'(out_valid), 1);
      chk({v.name, "_hold_nar"}, int'(out_nar), int'(e.nar));
      chk({v.name, "_hold_zero"}, int'(out_zero), int'(e.zero));
      chk({v.name, "_hold_rdy"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({v.name, "_post_valid"}, int'(out_valid), 0);
    chk({v.name, "_post_rdy"}, int'(in_ready), 1);
    chk({v.name, "_post_busy"}, int'(busy), 0);
    chk({v.name, "_post_flags"}, int'({out_nar, out_zero}), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    //          name       na nb za zb en ez  ea  mm  enc hold xn xz em enc to lat
    vt[0]  = mk("normal",   0, 0, 0, 0, 0, 0, 3,  1,  2,  0,  0, 0, 1, 1, 0, 7);
    vt[1]  = mk("narA_zB",  1, 0, 0, 1, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0, 0, 0);
    vt[2]  = mk("zeroA",    0, 0, 1, 0, 0, 0, 0,  0,  0,  0,  0, 1, 0, 0, 0, 0);
    vt[3]  = mk("narB",     0, 1, 0, 0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0, 0, 0);
    vt[4]  = mk("ea_ovf",   0, 0, 0, 0, 1, 0, 2,  2,  0,  0,  1, 0, 1, 0, 0, 3);
    vt[5]  = mk("ea_unf",   0, 0, 0, 0, 0, 1, 0,  0,  0,  0,  0, 1, 1, 0, 0, 1);
    vt[6]  = mk("ovf_late", 0, 0, 0, 0, 1, 0, 0,  3,  0,  0,  1, 0, 1, 0, 0, 4);
    vt[7]  = mk("unf_late", 0, 0, 0, 0, 0, 1, 5,  0,  0,  0,  0, 1, 1, 0, 0, 6);
    vt[8]  = mk("mm_late",  0, 0, 0, 0, 0, 0, 0,  4,  0,  0,  0, 0, 1, 1, 0, 6);
    vt[9]  = mk("wd_em",    0, 0, 0, 0, 0, 0, 1, NEVER, 0, 0, 1, 0, 1, 0, 1, 16);
    vt[10] = mk("after_wd", 0, 0, 0, 0, 0, 0, 1,  1,  1,  0,  0, 0, 1, 1, 0, 4);
    vt[11] = mk("em_at15",  0, 0, 0, 0, 0, 0, 15, 2,  0,  0,  0, 0, 1, 1, 0, 17);
    vt[12] = mk("wd_enc",   0, 0, 0, 0, 0, 0, 0,  0, NEVER, 0, 1, 0, 1, 1, 1, 17);
    vt[13] = mk("enc_at15", 0, 0, 0, 0, 0, 0, 0,  0, 15, 10, 0, 0, 1, 1, 0, 17);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_nar_A = 1'b0; in_nar_B = 1'b0; in_zero_A = 1'b0; in_zero_B = 1'b0;
    ea_done = 1'b0; ea_NaR = 1'b0; ea_zero = 1'b0;
    mm_done = 1'b0; enc_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_outputs", int'({ea_start, mm_start, enc_start, out_valid,
                             out_nar, out_zero, busy, err_timeout}), 0);

    for (int i = 0; i < 14; i++) run_vec(vt[i]);

    // Reset while waiting on the exponent/mantissa units.
    in_valid = 1'b1;
    in_nar_A = 1'b0; in_nar_B = 1'b0; in_zero_A = 1'b0; in_zero_B = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_em_busy", int'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0;
    chk("mid_rst_rdy", int'(in_ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_err", int'(err_timeout), 0);
    chk("mid_rst_outs", int'({ea_start, mm_start, enc_start, out_valid}), 0);
    ea_done = 1'b1; mm_done = 1'b1; ea_NaR = 1'b1; enc_done = 1'b1;
    @(negedge clk);
    ea_done = 1'b0; mm_done = 1'b0; ea_NaR = 1'b0; enc_done = 1'b0;
    @(negedge clk);
    chk("late_done_rdy", int'(in_ready), 1);
    chk("late_done_outs", int'({enc_start, out_valid, out_nar, busy}), 0);

    run_vec(vt[0]);
    run_vec(vt[2]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
